// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dly_mon_pkg.sv
// Shared types and constants for the delay-chain monitor.
// Build option: GF180MCU_FD_SC_MCU7T5V0_DLY_MON_SYNC3_EN selects a 3-flop synchronizer.
package gf180mcu_fd_sc_mcu7t5v0__dly_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } dly_mon_state_e;

`ifdef GF180MCU_FD_SC_MCU7T5V0_DLY_MON_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dly_mon_sync.sv
// Synchronizer for the free-running oscillator input with rising-edge detect.
// Depth comes from SYNC_STAGES (3 when GF180MCU_FD_SC_MCU7T5V0_DLY_MON_SYNC3_EN is defined).
module gf180mcu_fd_sc_mcu7t5v0__dly_mon_sync
  import gf180mcu_fd_sc_mcu7t5v0__dly_mon_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // These flops run in every FSM state so the pipeline is always fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dly_mon.sv
// Delay-chain monitor: counts oscillator rising edges over a programmable CLK window.
// Build option: GF180MCU_FD_SC_MCU7T5V0_DLY_MON_SYNC3_EN deepens the synchronizer to 3 flops.
module gf180mcu_fd_sc_mcu7t5v0__dly_mon
  import gf180mcu_fd_sc_mcu7t5v0__dly_mon_pkg::*;
#(
  parameter int WIN_W = 10,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN,
  input  logic             I,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int               SET_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // True when one more edge leaves the counter pinned at its maximum.
  function automatic logic sat_hits_max(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) || (v == CNT_MAX - CNT_W'(1));
  endfunction

  dly_mon_state_e   r_state;
  dly_mon_state_e   w_state_nxt;
  logic             w_start_acc;
  logic             w_win_last;
  logic             w_rise;
  logic [WIN_W-1:0] r_win_cnt;
  logic [SET_W-1:0] r_set_cnt;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  wire              w_pwr_unused;

  assign w_pwr_unused = VDD ^ VSS;

  gf180mcu_fd_sc_mcu7t5v0__dly_mon_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_async (I),
    .o_rise  (w_rise)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_win_last = (r_win_cnt == WIN_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_SETTLE;
          w_start_acc = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (r_set_cnt == '0)
          w_state_nxt = (r_win_cnt == '0) ? ST_DONE : ST_COUNT;
      end
      ST_COUNT: begin
        if (w_win_last) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Window length is latched once; the COUNT phase consumes it as a down-counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_win_cnt <= '0;
      r_set_cnt <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_win_cnt <= WIN;
        r_set_cnt <= SET_LOAD;
        r_count   <= '0;
        r_ovf     <= 1'b0;
      end
      if (r_state == ST_SETTLE && r_set_cnt != '0)
        r_set_cnt <= r_set_cnt - SET_W'(1);
      if (r_state == ST_COUNT) begin
        r_win_cnt <= r_win_cnt - WIN_W'(1);
        if (w_rise) begin
          r_count <= sat_inc(r_count);
          if (sat_hits_max(r_count)) r_ovf <= 1'b1;
        end
      end
    end
  end

  assign BUSY  = (r_state == ST_SETTLE) || (r_state == ST_COUNT);
  assign DONE  = (r_state == ST_DONE);
  assign COUNT = r_count;
  assign OVF   = r_ovf;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dly_mon.sv
// Directed bench for the delay-chain monitor: vector table plus corner-case sequences.
module tb_gf180mcu_fd_sc_mcu7t5v0__dly_mon;

`ifdef GF180MCU_FD_SC_MCU7T5V0_DLY_MON_SYNC3_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif
  localparam int WIN_W = 10;
  localparam int CNT_W = 8;
  localparam int BOUND = 2000;

  // I waveform modes
  localparam int M_ZERO = 0;
  localparam int M_SQ4  = 1;
  localparam int M_TOG  = 2;
  localparam int M_ONE  = 3;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [WIN_W-1:0] WIN;
  logic             I;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] COUNT;
  logic             OVF;
  wire              vdd = 1'b1;
  wire              vss = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = M_ZERO;
  int ph      = 0;

  gf180mcu_fd_sc_mcu7t5v0__dly_mon #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .WIN   (WIN),
    .I     (I),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .COUNT (COUNT),
    .OVF   (OVF),
    .VDD   (vdd),
    .VSS   (vss)
  );

  always #5 CLK = ~CLK;

  // Oscillator model: changes shortly after each rising CLK edge.
  initial begin
    I = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      ph++;
      case (mode)
        M_SQ4:   I = ((ph % 8) < 4);
        M_TOG:   I = ph[0];
        M_ONE:   I = 1'b1;
        default: I = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_mode(input int m);
    mode = m;
    repeat (6) tick();
  endtask

  // Issues START from IDLE and waits for DONE; returns latency and BUSY-high cycle count.
  task automatic run_meas(input int win, output int lat, output int busy_cyc);
    START = 1'b1;
    WIN   = WIN_W'(win);
    tick();
    START = 1'b0;
    WIN   = WIN_W'($urandom);
    lat = 1;
    busy_cyc = BUSY ? 1 : 0;
    while (!DONE && lat < BOUND) begin
      tick();
      lat++;
      if (BUSY) busy_cyc++;
    end
  endtask

  typedef struct {
    int mode;
    int win;
    int exp_cnt;
    int exp_ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, bcyc, dones, cnt_before;

    vecs[0] = '{M_SQ4, 64,  8,   0};
    vecs[1] = '{M_SQ4, 8,   1,   0};
    vecs[2] = '{M_TOG, 100, 50,  0};
    vecs[3] = '{M_TOG, 508, 254, 0};
    vecs[4] = '{M_TOG, 600, 255, 1};
    vecs[5] = '{M_ZERO, 64, 0,   0};
    vecs[6] = '{M_ONE, 40,  0,   0};
    vecs[7] = '{M_TOG, 0,   0,   0};
    vecs[8] = '{M_TOG, 2,   1,   0};

    RST = 1'b1; START = 1'b0; WIN = '0;
    tick();
    tick();
    RST = 1'b0;
    check("reset_busy",  int'(BUSY),  0);
    check("reset_done",  int'(DONE),  0);
    check("reset_count", int'(COUNT), 0);
    check("reset_ovf",   int'(OVF),   0);

    for (int k = 0; k < 9; k++) begin
      set_mode(vecs[k].mode);
      run_meas(vecs[k].win, lat, bcyc);
      check($sformatf("v%0d_latency", k), lat, vecs[k].win + N + 1);
      check($sformatf("v%0d_count", k), int'(COUNT), vecs[k].exp_cnt);
      check($sformatf("v%0d_ovf", k), int'(OVF), vecs[k].exp_ovf);
      check($sformatf("v%0d_busy_cycles", k), bcyc, vecs[k].win + N);
      tick();
      check($sformatf("v%0d_done_pulse", k), int'(DONE), 0);
      repeat (3) tick();
      check($sformatf("v%0d_count_hold", k), int'(COUNT), vecs[k].exp_cnt);
      check($sformatf("v%0d_ovf_hold", k), int'(OVF), vecs[k].exp_ovf);
    end

    // START repeated during COUNT and on the DONE cycle must be ignored.
    set_mode(M_SQ4);
    START = 1'b1;
    WIN   = WIN_W'(32);
    tick();
    START = 1'b0;
    lat = 1;
    dones = 0;
    while (!DONE && lat < BOUND) begin
      if (lat == 10) begin
        START = 1'b1;
        WIN   = WIN_W'(5);
      end else begin
        START = 1'b0;
      end
      tick();
      lat++;
    end
    check("ign_latency", lat, 32 + N + 1);
    check("ign_count", int'(COUNT), 4);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("ign_done_state_busy", int'(BUSY), 0);
    for (int c = 0; c < 60; c++) begin
      if (DONE) dones++;
      tick();
    end
    check("ign_extra_done", dones, 0);
    check("ign_count_hold", int'(COUNT), 4);
    run_meas(8, lat, bcyc);
    check("ign_next_latency", lat, 8 + N + 1);
    check("ign_next_count", int'(COUNT), 1);

    // Reset asserted in the 20th COUNT cycle discards the run.
    set_mode(M_TOG);
    START = 1'b1;
    WIN   = WIN_W'(64);
    tick();
    START = 1'b0;
    repeat (N + 19) tick();
    cnt_before = int'(COUNT);
    check("rst_mid_busy_before", int'(BUSY), 1);
    check("rst_mid_partial_nonzero", int'(cnt_before != 0), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_mid_busy", int'(BUSY), 0);
    check("rst_mid_count", int'(COUNT), 0);
    check("rst_mid_ovf", int'(OVF), 0);
    dones = 0;
    for (int c = 0; c < 100; c++) begin
      if (DONE) dones++;
      tick();
    end
    check("rst_mid_no_done", dones, 0);
    run_meas(0, lat, bcyc);
    check("rst_mid_restart_latency", lat, N + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__dly_mon.md
# gf180mcu_fd_sc_mcu7t5v0__dly_mon

Delay-chain monitor. Counts rising edges of a free-running ring oscillator built from `buf_2` cells over a programmable window of `CLK` cycles, and reports the result as a process/voltage/temperature figure of merit. It sits directly downstream of the buffer chain: the chain's output drives `I`, and the measured count goes to the on-chip test/trim logic.

## Interface
Parameters:
- `WIN_W`, 10: width of the window length, in `CLK` cycles.
- `CNT_W`, 8: width of the edge counter.

Ports:
- `CLK` input 1: the single clock. All state updates on its rising edge.
- `RST` input 1: reset. **Synchronous and active-high**, sampled on `CLK`.
- `START` input 1: measurement request. Sampled in IDLE only.
- `WIN` input WIN_W: window length in `CLK` cycles. Latched when `START` is accepted.
- `I` input 1: oscillator output. Asynchronous to `CLK`.
- `BUSY` output 1: a measurement is in progress.
- `DONE` output 1: one-cycle pulse marking that `COUNT`/`OVF` are valid.
- `COUNT` output CNT_W: number of `I` rising edges in the last window. Saturates.
- `OVF` output 1: the counter saturated during the last window.
- `VDD`, `VSS` inout 1: power pins. Functional model only, no logic.

## Operation
- `I` passes through an N-flop synchronizer, N=2. A third flop holds the previous value.
  - Rising edge detected when the synchronized value is 1 and the previous value is 0.
  - The synchronizer flops always run, including in IDLE.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE
  - `START`=1: latch `WIN`, clear `COUNT` and `OVF`, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE
  - Lasts N cycles to flush stale synchronizer contents.
  - Then go to COUNT, or straight to DONE if the latched `WIN`=0.
- COUNT
  - Lasts exactly `WIN` cycles. Each detected edge increments `COUNT`.
  - At `2^CNT_W-1` the counter holds and sets `OVF`. `OVF` stays set until the next accepted `START`.
  - After the last window cycle, go to DONE.
- DONE: lasts one cycle with `DONE`=1, then IDLE.
- `BUSY`=1 in SETTLE and COUNT, 0 in IDLE and DONE.
- `START` in SETTLE, COUNT or DONE is ignored. It is not queued.
- `COUNT` and `OVF` hold their values from DONE until the next accepted `START`.
- The `WIN` input is ignored after it is latched.
- An edge detected on the same cycle the counter reaches its maximum is absorbed by saturation. No wrap-around, ever.

## Timing
- Reset values: state IDLE, `BUSY`=0, `DONE`=0, `COUNT`=0, `OVF`=0, synchronizer flops 0.
- `RST` overrides everything on the same edge, including mid-window. The partial count is discarded.
- Cycle map, with `START` accepted at cycle t:
  - `BUSY` rises at t+1.
  - SETTLE covers t+1..t+N.
  - COUNT covers t+N+1..t+N+WIN.
  - `DONE`=1 at t+N+WIN+1.
- Latency from `START` to `DONE` is WIN+N+1 cycles (WIN+3 at default). With `WIN`=0 it is N+1.
- Earliest next accepted `START` is the cycle after DONE.
- Valid measurement requires the `I` frequency to be below `CLK`/2. Edges beyond that are not guaranteed.

## Configuration
- Macro `GF180MCU_FD_SC_MCU7T5V0_DLY_MON_SYNC3_EN`.
- Defined: synchronizer depth N=3, SETTLE lasts 3 cycles, `START`-to-`DONE` latency is WIN+4.
- Undefined: N=2, latency WIN+3.
- No other behaviour changes.

## Structure
- Package `gf180mcu_fd_sc_mcu7t5v0__dly_mon_pkg` holds:
  - the FSM state enum;
  - the constant `SYNC_STAGES`, which is 2, or 3 under the macro.
- Sub-module `gf180mcu_fd_sc_mcu7t5v0__dly_mon_sync`:
  - synchronizer plus previous-value flop and rising-edge output;
  - parameterized by `SYNC_STAGES`; reset by `RST`.
- The top holds the FSM, the window down-counter and the saturating edge counter.

## Test plan
- Reset: assert `RST` for 2 cycles. Then `BUSY`=0, `DONE`=0, `COUNT`=0, `OVF`=0.
- Nominal: drive `I` as a square wave, 4 cycles high and 4 low. `WIN`=64 and a `START` pulse give `DONE` exactly 67 cycles later with `COUNT`=8 and `OVF`=0.
- Saturation: toggle `I` every cycle (period 2 cycles). `WIN`=600 gives `COUNT`=255 and `OVF`=1. A following run with `I` held at 0 gives `COUNT`=0 and `OVF`=0.
- Zero window: `WIN`=0 gives `DONE` 3 cycles after `START`, `COUNT`=0, and `BUSY` high for 2 cycles.
- Ignored requests: repeat `START` during COUNT and on the DONE cycle. Exactly one `DONE` pulse and an unchanged result; the next measurement is accepted only from IDLE.
- Reset mid-window: assert `RST` in the 20th COUNT cycle. On the next cycle the state is IDLE with `BUSY`=0 and `COUNT`=0, and no `DONE` pulse ever appears for that run.
